// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset/step defaults and the {pc, inst} queue entry for the fetch front end.
// No ports; imported by fetch_queue, inst_fetch and the bench.
package fetch_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_RESET_PC   = 0;
    localparam int DEF_PC_STEP    = 4;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0] pc;
        logic [DEF_DATA_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry synchronous FIFO with flush; head is always slot 0.
// Ports: clk, rst (async, active-high), flush (empties queue, beats push/pop),
//        push/din (enqueue), pop (dequeue head), count (0..2), head (slot 0 contents).
module fetch_queue #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   count_q, count_d;
    logic [1:0]   wr_idx;

    // After an optional pop the survivors shift toward slot 0, so the write
    // slot is the post-pop occupancy; the caller never pushes into a full queue.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        wr_idx  = count_q - {1'b0, pop};
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop)
                e0_d = e1_q;
            if (push && wr_idx == 2'd0)
                e0_d = din;
            if (push && wr_idx != 2'd0)
                e1_d = din;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = e0_q;

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC register driving InsMEM, sequential step / redirect, 2-deep {pc, inst} queue toward decode.
// Ports: sys_clk, sys_rst (async, active-high); InsAddr/InsData (combinational memory port);
//        fetch_en, redirect_valid/redirect_pc (control); out_valid/out_ready/out_pc/out_inst (decode
//        handshake); misaligned_err (one-cycle pulse after a redirect target with nonzero [1:0]).
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC),
    parameter logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(DEF_PC_STEP)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    output logic [ADDR_WIDTH-1:0] InsAddr,
    input  logic [DATA_WIDTH-1:0] InsData,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic                  misaligned_err
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  err_q, err_d;
    logic [1:0]            count;
    logic                  pop, push;

    assign pop  = out_valid & out_ready;
    // A same-cycle pop frees a slot, which keeps 1/cycle flow with the queue full.
    assign push = fetch_en & ~redirect_valid & (count != 2'd2 | pop);

    always_comb begin
        pc_d  = redirect_valid ? {redirect_pc[ADDR_WIDTH-1:2], 2'b00} : push ? pc_q + PC_STEP : pc_q;
        err_d = redirect_valid & (redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    fetch_queue #(.W(ADDR_WIDTH + DATA_WIDTH)) u_queue (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({pc_q, InsData}),
        .count (count),
        .head  ({out_pc, out_inst})
    );

    assign InsAddr        = pc_q;
    assign out_valid      = count != 2'd0;
    assign misaligned_err = err_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized and directed checks of inst_fetch against a queue-based reference model.
module tb_inst_fetch;
    import fetch_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [31:0] ins_addr, ins_data, redirect_pc, out_pc, out_inst;
    logic        fetch_en = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
    logic        out_valid, misaligned_err;
    logic [31:0] salt = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_entry_t mq[$];
    logic [31:0]  m_pc;
    logic         m_err;

    assign ins_data = (ins_addr >> 2) ^ salt;

    always #5 sys_clk = ~sys_clk;

    inst_fetch dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .InsAddr        (ins_addr),
        .InsData        (ins_data),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .misaligned_err (misaligned_err)
    );

    task automatic model_reset();
        mq.delete();
        m_pc  = 32'h0;
        m_err = 1'b0;
    endtask

    // Advance the reference model with the currently driven inputs, then the DUT by one clock.
    task automatic tick();
        bit           pop;
        fetch_entry_t e;
        pop = mq.size() != 0 && out_ready;
        if (redirect_valid) begin
            mq.delete();
            m_err = redirect_pc[1:0] != 2'b00;
            m_pc  = redirect_pc & ~32'h3;
        end else begin
            m_err = 1'b0;
            if (pop)
                void'(mq.pop_front());
            if (fetch_en && mq.size() < 2) begin
                e.pc   = m_pc;
                e.inst = (m_pc >> 2) ^ salt;
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        sys_rst        = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 5;
        if (ins_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=%h", ins_addr, 32'h0); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
        if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_out_inst got=%h exp=0", out_inst); end
        if (misaligned_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", misaligned_err); end
    endtask

    task automatic test_stream();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_first_valid got=%b exp=1", out_valid); end
        for (int i = 0; i < 4; i++) begin
            n_checks += 3;
            if (out_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, out_pc, 32'(i * 4)); end
            if (out_inst !== 32'(i)) begin n_fail++; $display("FAIL stream_inst[%0d] got=%h exp=%h", i, out_inst, 32'(i)); end
            if (ins_addr !== 32'((i + 1) * 4)) begin n_fail++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, ins_addr, 32'((i + 1) * 4)); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h0;
        exp_pc[1] = 32'h4;
        exp_pc[2] = 32'h8;
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            tick();
        n_checks += 3;
        if (ins_addr !== 32'h8) begin n_fail++; $display("FAIL bp_addr_hold got=%h exp=8", ins_addr); end
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
        if (out_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head_stable got=%h exp=0", out_pc); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks += 2;
            if (out_pc !== exp_pc[i]) begin n_fail++; $display("FAIL bp_drain_pc[%0d] got=%h exp=%h", i, out_pc, exp_pc[i]); end
            if (out_inst !== exp_pc[i] >> 2) begin n_fail++; $display("FAIL bp_drain_inst[%0d] got=%h exp=%h", i, out_inst, exp_pc[i] >> 2); end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got=%b exp=0", out_valid); end
        if (ins_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr got=%h exp=100", ins_addr); end
        if (misaligned_err !== 1'b0) begin n_fail++; $display("FAIL redir_err got=%b exp=0", misaligned_err); end
        tick();
        n_checks += 3;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid got=%b exp=1", out_valid); end
        if (out_pc !== 32'h100) begin n_fail++; $display("FAIL redir_out_pc got=%h exp=100", out_pc); end
        if (misaligned_err !== 1'b0) begin n_fail++; $display("FAIL redir_err2 got=%b exp=0", misaligned_err); end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        fetch_en       = 1'b0;
        n_checks += 2;
        if (ins_addr !== 32'h100) begin n_fail++; $display("FAIL mis_addr got=%h exp=100", ins_addr); end
        if (misaligned_err !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got=%b exp=1", misaligned_err); end
        tick();
        n_checks++;
        if (misaligned_err !== 1'b0) begin n_fail++; $display("FAIL mis_single got=%b exp=0", misaligned_err); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks += 2;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid[%0d] got=%b exp=1", i, out_valid); end
            if (out_pc !== exp_pc[i]) begin n_fail++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", i, out_pc, exp_pc[i]); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        tick();
        tick();
        #2;
        sys_rst = 1'b1;
        #1;
        n_checks += 2;
        if (ins_addr !== 32'h0) begin n_fail++; $display("FAIL async_addr got=%h exp=0", ins_addr); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid got=%b exp=0", out_valid); end
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        do_reset();
        salt = $urandom;
        for (int i = 0; i < 400; i++) begin
            fetch_en       = ($urandom_range(0, 9) < 8);
            out_ready      = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            tick();
            n_checks += 3;
            if (ins_addr !== m_pc) begin n_fail++; $display("FAIL rand_addr[%0d] got=%h exp=%h", i, ins_addr, m_pc); end
            if (out_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, out_valid, mq.size() != 0); end
            if (misaligned_err !== m_err) begin n_fail++; $display("FAIL rand_err[%0d] got=%b exp=%b", i, misaligned_err, m_err); end
            if (mq.size() != 0) begin
                n_checks += 2;
                if (out_pc !== mq[0].pc) begin n_fail++; $display("FAIL rand_pc[%0d] got=%h exp=%h", i, out_pc, mq[0].pc); end
                if (out_inst !== mq[0].inst) begin n_fail++; $display("FAIL rand_inst[%0d] got=%h exp=%h", i, out_inst, mq[0].inst); end
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge sys_clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch front end that acts as the initiator toward the combinational InsMEM read port.
- Holds the PC and drives InsAddr; captures the returned InsData the same cycle.
- Steps the PC by 4 and accepts branch/jump redirects.
- Buffers fetched {pc, instruction} pairs in a 2-entry queue and hands them to decode over a valid/ready handshake.

Parameters:
DATA_WIDTH, 32, instruction width
ADDR_WIDTH, 32, PC / InsAddr width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, PC increment per sequential fetch

Ports:
sys_clk  input  1  clock; all state updates on posedge
sys_rst  input  1  asynchronous, active-high reset
InsAddr  output  ADDR_WIDTH  address to InsMEM; equals current PC register
InsData  input  DATA_WIDTH  instruction from InsMEM; combinational from InsAddr
fetch_en  input  1  permits sequential fetch this cycle
redirect_valid  input  1  one-cycle request to jump the PC
redirect_pc  input  ADDR_WIDTH  redirect target
out_valid  output  1  queue head holds a valid instruction
out_ready  input  1  decode accepts head this cycle
out_pc  output  ADDR_WIDTH  PC of head instruction
out_inst  output  DATA_WIDTH  head instruction
misaligned_err  output  1  one-cycle pulse for a redirect target with [1:0] != 0

Behaviour:
- Reset (asynchronous, takes effect immediately while sys_rst=1):
  - pc = RESET_PC, so InsAddr = RESET_PC.
  - Queue emptied: count = 0, out_valid = 0, out_pc = 0, out_inst = 0.
  - misaligned_err = 0.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count < 2 | pop).
  - On push: enqueue {pc, InsData} and set pc <= pc + PC_STEP, modulo 2^ADDR_WIDTH (0xFFFFFFFC -> 0x00000000).
- Redirect (redirect_valid = 1) has priority over fetch and pop:
  - Queue flushed to count = 0, so out_valid = 0 the next cycle; any pop that cycle is discarded and no push occurs.
  - pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - misaligned_err = 1 the next cycle iff redirect_pc[1:0] != 0; otherwise 0. It is a single-cycle pulse.
- Queue: 2-entry FIFO; head drives out_pc and out_inst.
  - Outputs are registered; out_valid = (count != 0).
  - Fetch-to-out_valid latency is 1 cycle.
  - Push and pop in the same cycle leave count unchanged and preserve order.
  - Full (count = 2) without pop: push is blocked and the PC holds.
  - Empty: pop is impossible since out_valid = 0.
  - Data is stable while out_valid & ~out_ready (no change until accepted).
- fetch_en = 0: PC holds, no push; pops continue.
- Priority order: sys_rst > redirect_valid > push/pop.
- Sustained throughput is 1 instruction per cycle when out_ready is held at 1.

Decomposition:
- Shared package fetch_pkg: ADDR_WIDTH/DATA_WIDTH defaults, RESET_PC, PC_STEP, and the packed fetch_entry_t {pc, inst}.
- One sub-module, fetch_queue: 2-entry synchronous FIFO with flush input, push/pop, count, and head output.
- PC, redirect, and error logic stay in inst_fetch.

Test Plan:
- Reset then fetch_en=1, out_ready=1, InsData = pc>>2:
  - Expect out_valid rising 1 cycle after reset release.
  - out_pc sequence 0, 4, 8, 12, with out_inst 0, 1, 2, 3, one per cycle.
- out_ready=0 for 5 cycles with fetch_en=1:
  - count saturates at 2 and InsAddr holds at 8.
  - Head stays pc=0 until ready returns, then 0, 4, 8 drain in order with no loss or duplicate.
- Redirect to 0x100 while queue holds 2 entries:
  - Next cycle out_valid=0 and InsAddr=0x100.
  - Following cycle out_pc=0x100; misaligned_err stays 0.
- Redirect to 0x102: InsAddr=0x100 next cycle and misaligned_err=1 for exactly one cycle.
- Redirect to 0xFFFFFFF8, then fetch: out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Assert sys_rst mid-stream between clock edges: InsAddr=RESET_PC and out_valid=0 immediately, before the next posedge.
